// File: rtl/stopwatch_time_counter.sv
// BCD stopwatch time counter MM:SS.mmm driven by single-cycle 1 ms ticks.
// Optional lap-hold display is built when STOPWATCH_LAP_HOLD_EN is defined.
module stopwatch_time_counter #(
  parameter logic [3:0] RUN_STATE   = 4'd3,
  parameter logic [3:0] CLEAR_STATE = 4'd1,
  parameter int         MAX_MINUTES = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] state,
  input  logic       oneMilliSecond,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [3:0] ms_d0,
  output logic [3:0] ms_d1,
  output logic [3:0] ms_d2,
  output logic [3:0] sec_d0,
  output logic [3:0] sec_d1,
  output logic [3:0] min_d0,
  output logic [3:0] min_d1,
  output logic       rollover,
  output logic       overflowed
);

  localparam logic [3:0] MIN_TENS_MAX = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MIN_ONES_MAX = 4'(MAX_MINUTES % 10);

  // Live (internal) time digits.
  logic [3:0] msD0;
  logic [3:0] msD1;
  logic [3:0] msD2;
  logic [3:0] secD0;
  logic [3:0] secD1;
  logic [3:0] minD0;
  logic [3:0] minD1;

  logic clearReq;
  logic runTick;
  logic carryMs1;
  logic carryMs2;
  logic carrySec0;
  logic carrySec1;
  logic carryMin0;
  logic minAtMax;
  logic minOnesWrap;
  logic fullWrap;

  assign clearReq = (state == CLEAR_STATE);
  assign runTick  = (state == RUN_STATE) && oneMilliSecond;

  // Ripple of enables: each digit advances only when all lower digits are terminal.
  assign carryMs1  = runTick   && (msD0  == 4'd9);
  assign carryMs2  = carryMs1  && (msD1  == 4'd9);
  assign carrySec0 = carryMs2  && (msD2  == 4'd9);
  assign carrySec1 = carrySec0 && (secD0 == 4'd9);
  assign carryMin0 = carrySec1 && (secD1 == 4'd5);

  assign minAtMax    = (minD1 == MIN_TENS_MAX) && (minD0 == MIN_ONES_MAX);
  assign minOnesWrap = minAtMax || (minD0 == 4'd9);
  assign fullWrap    = carryMin0 && minAtMax;

  always_ff @(posedge clk) begin
    if (reset || clearReq) begin
      msD0       <= 4'd0;
      msD1       <= 4'd0;
      msD2       <= 4'd0;
      secD0      <= 4'd0;
      secD1      <= 4'd0;
      minD0      <= 4'd0;
      minD1      <= 4'd0;
      rollover   <= 1'b0;
      overflowed <= 1'b0;
    end else begin
      if (runTick) begin
        msD0 <= (msD0 == 4'd9) ? 4'd0 : msD0 + 4'd1;
      end
      if (carryMs1) begin
        msD1 <= (msD1 == 4'd9) ? 4'd0 : msD1 + 4'd1;
      end
      if (carryMs2) begin
        msD2 <= (msD2 == 4'd9) ? 4'd0 : msD2 + 4'd1;
      end
      if (carrySec0) begin
        secD0 <= (secD0 == 4'd9) ? 4'd0 : secD0 + 4'd1;
      end
      if (carrySec1) begin
        secD1 <= (secD1 == 4'd5) ? 4'd0 : secD1 + 4'd1;
      end
      // Minute pair wraps to 00 at MAX_MINUTES, otherwise ordinary BCD carry.
      if (carryMin0) begin
        minD0 <= minOnesWrap ? 4'd0 : minD0 + 4'd1;
      end
      if (carryMin0 && minOnesWrap) begin
        minD1 <= minAtMax ? 4'd0 : minD1 + 4'd1;
      end
      rollover   <= fullWrap;
      overflowed <= overflowed | fullWrap;
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam logic [0:0] MODE_LIVE = 1'b0;
  localparam logic [0:0] MODE_SNAP = 1'b1;

  logic       lapQ;
  logic       lapRise;
  logic [0:0] dispMode;
  logic [3:0] snapMs0;
  logic [3:0] snapMs1;
  logic [3:0] snapMs2;
  logic [3:0] snapSec0;
  logic [3:0] snapSec1;
  logic [3:0] snapMin0;
  logic [3:0] snapMin1;

  assign lapRise = lap && !lapQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      lapQ <= 1'b0;
    end else begin
      lapQ <= lap;
    end
  end

  // Snapshot captures the live time as it stands before this edge's update.
  always_ff @(posedge clk) begin
    if (reset || clearReq) begin
      dispMode <= MODE_LIVE;
      snapMs0  <= 4'd0;
      snapMs1  <= 4'd0;
      snapMs2  <= 4'd0;
      snapSec0 <= 4'd0;
      snapSec1 <= 4'd0;
      snapMin0 <= 4'd0;
      snapMin1 <= 4'd0;
    end else if (lapRise) begin
      if (dispMode == MODE_LIVE) begin
        dispMode <= MODE_SNAP;
        snapMs0  <= msD0;
        snapMs1  <= msD1;
        snapMs2  <= msD2;
        snapSec0 <= secD0;
        snapSec1 <= secD1;
        snapMin0 <= minD0;
        snapMin1 <= minD1;
      end else begin
        dispMode <= MODE_LIVE;
      end
    end
  end

  always_comb begin
    ms_d0  = msD0;
    ms_d1  = msD1;
    ms_d2  = msD2;
    sec_d0 = secD0;
    sec_d1 = secD1;
    min_d0 = minD0;
    min_d1 = minD1;
    if (dispMode == MODE_SNAP) begin
      ms_d0  = snapMs0;
      ms_d1  = snapMs1;
      ms_d2  = snapMs2;
      sec_d0 = snapSec0;
      sec_d1 = snapSec1;
      min_d0 = snapMin0;
      min_d1 = snapMin1;
    end
  end
`else
  assign ms_d0  = msD0;
  assign ms_d1  = msD1;
  assign ms_d2  = msD2;
  assign sec_d0 = secD0;
  assign sec_d1 = secD1;
  assign min_d0 = minD0;
  assign min_d1 = minD1;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: directed steps plus random ticks against a
// millisecond-count reference model; lap steps build with STOPWATCH_LAP_HOLD_EN.
module tb_stopwatch_time_counter;

  localparam int MAX_MINUTES = 59;
  localparam int MAX_T       = MAX_MINUTES * 60000 + 59999;
`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] state;
  logic       oneMilliSecond;
  logic       lap;
  logic [3:0] ms_d0, ms_d1, ms_d2, sec_d0, sec_d1, min_d0, min_d1;
  logic       rollover, overflowed;

  always #5 clk = ~clk;

  stopwatch_time_counter #(
    .RUN_STATE(4'd3),
    .CLEAR_STATE(4'd1),
    .MAX_MINUTES(MAX_MINUTES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state(state),
    .oneMilliSecond(oneMilliSecond),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .ms_d0(ms_d0),
    .ms_d1(ms_d1),
    .ms_d2(ms_d2),
    .sec_d0(sec_d0),
    .sec_d1(sec_d1),
    .min_d0(min_d0),
    .min_d1(min_d1),
    .rollover(rollover),
    .overflowed(overflowed)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: time held as a plain millisecond count.
  int tm      = 0;
  bit ovExp   = 1'b0;
  bit rollExp = 1'b0;
  bit lapPrev = 1'b0;
  bit showSnap = 1'b0;
  int snapT   = 0;

  logic [27:0] preVal;
  logic [27:0] shown;
  assign shown = {min_d1, min_d0, sec_d1, sec_d0, ms_d2, ms_d1, ms_d0};

  function automatic logic [27:0] toBcd(input int t);
    int m, s, ms;
    m  = t / 60000;
    s  = (t / 1000) % 60;
    ms = t % 1000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            4'(ms / 100), 4'((ms / 10) % 10), 4'(ms % 10)};
  endfunction

  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 after it.
  task automatic cycle(input logic [3:0] st, input logic tk, input logic rs, input logic lp);
    bit lapRise;
    int expShown;
    state = st;
    oneMilliSecond = tk;
    reset = rs;
    lap = lp;
    @(posedge clk);
    lapRise = LAP_EN && lp && !lapPrev;
    lapPrev = rs ? 1'b0 : lp;
    if (rs) begin
      tm = 0; ovExp = 0; rollExp = 0; showSnap = 0; snapT = 0;
    end else if (st == 4'd1) begin
      tm = 0; ovExp = 0; rollExp = 0; showSnap = 0; snapT = 0;
    end else begin
      if (lapRise) begin
        if (showSnap) showSnap = 0;
        else begin
          snapT = tm;
          showSnap = 1;
        end
      end
      if (st == 4'd3 && tk) begin
        if (tm == MAX_T) begin
          tm = 0; rollExp = 1; ovExp = 1;
        end else begin
          tm++; rollExp = 0;
        end
      end else begin
        rollExp = 0;
      end
    end
    #1;
    expShown = showSnap ? snapT : tm;
    check("time", shown, toBcd(expShown));
    check("rollover", {27'd0, rollover}, {27'd0, rollExp});
    check("overflowed", {27'd0, overflowed}, {27'd0, ovExp});
  endtask

  // Deposits a time straight into the live digit registers.
  task automatic preload(input int t);
    preVal = toBcd(t);
    force dut.minD1 = preVal[27:24];
    force dut.minD0 = preVal[23:20];
    force dut.secD1 = preVal[19:16];
    force dut.secD0 = preVal[15:12];
    force dut.msD2  = preVal[11:8];
    force dut.msD1  = preVal[7:4];
    force dut.msD0  = preVal[3:0];
    #1;
    release dut.minD1;
    release dut.minD0;
    release dut.secD1;
    release dut.secD0;
    release dut.msD2;
    release dut.msD1;
    release dut.msD0;
    tm = t;
  endtask

  initial begin
    state = 4'd0;
    oneMilliSecond = 1'b0;
    reset = 1'b1;
    lap = 1'b0;
    @(negedge clk);
    cycle(4'd0, 1'b1, 1'b1, 1'b0);
    cycle(4'd3, 1'b1, 1'b1, 1'b0);
    check("reset_time", shown, 28'h0000000);

    // 1000 ticks -> 00:01.000
    repeat (1000) cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("one_second", shown, 28'h0001000);

    // 00:09.999 + tick -> 00:10.000
    repeat (8999) cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("at_9_999", shown, 28'h0009999);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("to_10_000", shown, 28'h0010000);

    // 00:59.999 + tick -> 01:00.000
    preload(59999);
    cycle(4'd2, 1'b0, 1'b0, 1'b0);
    check("preload_59_999", shown, 28'h0059999);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("to_1_minute", shown, 28'h0100000);

    // Full wrap from MAX:59.999
    preload(MAX_T);
    cycle(4'd2, 1'b0, 1'b0, 1'b0);
    check("preload_max", shown, toBcd(MAX_T));
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("wrap_zero", shown, 28'h0000000);
    check("wrap_rollover", {27'd0, rollover}, 28'd1);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("rollover_one_cycle", {27'd0, rollover}, 28'd0);
    repeat (4) cycle(4'd2, 1'b1, 1'b0, 1'b0);
    check("overflow_sticky", {27'd0, overflowed}, 28'd1);

    // Run / stop / run
    cycle(4'd1, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("run_5", shown, 28'h0000005);
    repeat (3) cycle(4'd2, 1'b1, 1'b0, 1'b0);
    check("stop_hold", shown, 28'h0000005);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("resume", shown, 28'h0000006);

    // Clear wins over a tick, and clears the sticky flag
    preload(MAX_T);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    preload(12345);
    cycle(4'd2, 1'b0, 1'b0, 1'b0);
    check("preload_12_345", shown, 28'h0012345);
    cycle(4'd1, 1'b1, 1'b0, 1'b0);
    check("clear_with_tick", shown, 28'h0000000);
    check("clear_overflow", {27'd0, overflowed}, 28'd0);

    // Reset during a tick
    repeat (7) cycle(4'd3, 1'b1, 1'b0, 1'b0);
    cycle(4'd3, 1'b1, 1'b1, 1'b0);
    check("reset_with_tick", shown, 28'h0000000);
    cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("after_reset", shown, 28'h0000001);

`ifdef STOPWATCH_LAP_HOLD_EN
    cycle(4'd1, 1'b0, 1'b0, 1'b0);
    preload(2500);
    cycle(4'd2, 1'b0, 1'b0, 1'b1);
    cycle(4'd2, 1'b0, 1'b0, 1'b0);
    repeat (500) cycle(4'd3, 1'b1, 1'b0, 1'b0);
    check("lap_hold", shown, 28'h0002500);
    cycle(4'd2, 1'b0, 1'b0, 1'b1);
    check("lap_release", shown, 28'h0003000);
    cycle(4'd2, 1'b0, 1'b0, 1'b0);
`endif

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] st;
      r = int'($urandom_range(0, 99));
      if (r < 80) st = 4'd3;
      else if (r < 94) st = 4'd2;
      else if (r < 98) st = 4'd0;
      else st = 4'd1;
      cycle(st, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 499) == 0),
            1'($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
